// File: rtl/mat_complex_out_stream.sv
// Captures a packed NxN complex-double matrix on the rising edge of done_in and streams it out, one element per valid/ready beat.
// Optional macro MAT_STREAM_TRANSPOSE_EN selects column-major emission order. The default order is row-major.
module mat_complex_out_stream #(
   parameter  int mat_num_row = 2,
   localparam int NE          = mat_num_row * mat_num_row,
   localparam int W           = 2 * 64 * NE,
   localparam int IDX_W       = (mat_num_row > 1) ? $clog2(mat_num_row) : 1,
   localparam int K_W         = (NE > 1) ? $clog2(NE) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     mat_in,
   input  logic             done_in,
   output logic [63:0]      out_real,
   output logic [63:0]      out_imag,
   output logic [IDX_W-1:0] out_row,
   output logic [IDX_W-1:0] out_col,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic             overrun
);

   localparam logic [0:0]       ST_IDLE   = 1'b0;
   localparam logic [0:0]       ST_STREAM = 1'b1;
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(mat_num_row - 1);

   logic [0:0]       r_state;
   logic             r_done_d;
   logic [W-1:0]     r_buf;
   logic [IDX_W-1:0] r_row;
   logic [IDX_W-1:0] r_col;
   logic [63:0]      r_real;
   logic [63:0]      r_imag;
   logic             r_valid;
   logic             r_last;
   logic             r_overrun;

   logic [63:0]      w_buf_re [NE];
   logic [63:0]      w_buf_im [NE];
   logic             w_rise;
   logic             w_beat;
   logic             w_last_beat;
   logic             w_capture;
   logic [IDX_W-1:0] w_row_nxt;
   logic [IDX_W-1:0] w_col_nxt;
   logic [K_W-1:0]   w_k_nxt;
   logic             w_last_nxt;

   genvar gi;
   generate
      for (gi = 0; gi < NE; gi++) begin : g_elem
         assign w_buf_re[gi] = r_buf[64*gi +: 64];
         assign w_buf_im[gi] = r_buf[64*gi + 64*NE +: 64];
      end
   endgenerate

   assign w_rise      = done_in & ~r_done_d;
   assign w_beat      = r_valid & out_ready;
   assign w_last_beat = w_beat & r_last;
   // A rise coinciding with the final beat chains straight into the next matrix.
   assign w_capture   = w_rise & ((r_state == ST_IDLE) | w_last_beat);

   always_comb begin
      w_row_nxt = r_row;
      w_col_nxt = r_col;
`ifdef MAT_STREAM_TRANSPOSE_EN
      if (r_row == IDX_MAX) begin
         w_row_nxt = '0;
         w_col_nxt = r_col + 1'b1;
      end else begin
         w_row_nxt = r_row + 1'b1;
      end
`else
      if (r_col == IDX_MAX) begin
         w_col_nxt = '0;
         w_row_nxt = r_row + 1'b1;
      end else begin
         w_col_nxt = r_col + 1'b1;
      end
`endif
      w_k_nxt    = K_W'(int'(w_row_nxt) * mat_num_row + int'(w_col_nxt));
      w_last_nxt = (w_row_nxt == IDX_MAX) && (w_col_nxt == IDX_MAX);
   end

   // The buffer is pure data storage, so it has no reset.
   always_ff @(posedge clk) begin
      if (w_capture) r_buf <= mat_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_done_d  <= 1'b0;
         r_row     <= '0;
         r_col     <= '0;
         r_real    <= '0;
         r_imag    <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_done_d <= done_in;
         if (w_capture) begin
            r_state <= ST_STREAM;
            r_row   <= '0;
            r_col   <= '0;
            r_real  <= mat_in[63:0];
            r_imag  <= mat_in[64*NE +: 64];
            r_valid <= 1'b1;
            r_last  <= (NE == 1);
         end else if (r_state == ST_STREAM) begin
            if (w_rise) r_overrun <= 1'b1;
            if (w_last_beat) begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
            end else if (w_beat) begin
               r_row  <= w_row_nxt;
               r_col  <= w_col_nxt;
               r_real <= w_buf_re[w_k_nxt];
               r_imag <= w_buf_im[w_k_nxt];
               r_last <= w_last_nxt;
            end
         end
      end
   end

   assign out_real  = r_real;
   assign out_imag  = r_imag;
   assign out_row   = r_row;
   assign out_col   = r_col;
   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign busy      = (r_state == ST_STREAM);
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_mat_complex_out_stream.sv
// Bench for mat_complex_out_stream. It runs directed N=2 sequences and random N=1, N=2 and N=3 streams.
// Expected values come from a queue-based model built from the element-order rules.
module tb_mat_complex_out_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        out_ready;
   logic        done1, done2, done3;
   logic [63:0] e_re [9];
   logic [63:0] e_im [9];
   logic [127:0]  mat1;
   logic [511:0]  mat2;
   logic [1151:0] mat3;

   always_comb begin
      mat1 = '0;
      mat2 = '0;
      mat3 = '0;
      for (int k = 0; k < 1; k++) begin
         mat1[64*k +: 64]      = e_re[k];
         mat1[64*k + 64 +: 64] = e_im[k];
      end
      for (int k = 0; k < 4; k++) begin
         mat2[64*k +: 64]       = e_re[k];
         mat2[64*k + 256 +: 64] = e_im[k];
      end
      for (int k = 0; k < 9; k++) begin
         mat3[64*k +: 64]       = e_re[k];
         mat3[64*k + 576 +: 64] = e_im[k];
      end
   end

   logic [63:0] o1_real, o1_imag, o2_real, o2_imag, o3_real, o3_imag;
   logic [0:0]  o1_row, o1_col, o2_row, o2_col;
   logic [1:0]  o3_row, o3_col;
   logic        o1_valid, o1_last, o1_busy, o1_ovr;
   logic        o2_valid, o2_last, o2_busy, o2_ovr;
   logic        o3_valid, o3_last, o3_busy, o3_ovr;

   mat_complex_out_stream #(.mat_num_row(1)) dut1 (
      .clk(clk), .rst(rst), .mat_in(mat1), .done_in(done1),
      .out_real(o1_real), .out_imag(o1_imag), .out_row(o1_row), .out_col(o1_col),
      .out_valid(o1_valid), .out_ready(out_ready), .out_last(o1_last),
      .busy(o1_busy), .overrun(o1_ovr));

   mat_complex_out_stream #(.mat_num_row(2)) dut (
      .clk(clk), .rst(rst), .mat_in(mat2), .done_in(done2),
      .out_real(o2_real), .out_imag(o2_imag), .out_row(o2_row), .out_col(o2_col),
      .out_valid(o2_valid), .out_ready(out_ready), .out_last(o2_last),
      .busy(o2_busy), .overrun(o2_ovr));

   mat_complex_out_stream #(.mat_num_row(3)) dut3 (
      .clk(clk), .rst(rst), .mat_in(mat3), .done_in(done3),
      .out_real(o3_real), .out_imag(o3_imag), .out_row(o3_row), .out_col(o3_col),
      .out_valid(o3_valid), .out_ready(out_ready), .out_last(o3_last),
      .busy(o3_busy), .overrun(o3_ovr));

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [63:0] re;
      logic [63:0] im;
      int          row;
      int          col;
      logic        last;
   } beat_t;
   beat_t q1[$], q2[$], q3[$];

   typedef struct {
      logic done;
      logic ready;
      logic v;
      int   p;
      logic last;
   } vec_t;
   vec_t tbl[18];

   function automatic vec_t mk(logic d, logic r, logic v, int p, logic l);
      vec_t t;
      t.done = d; t.ready = r; t.v = v; t.p = p; t.last = l;
      return t;
   endfunction

   // Source element index k = i*N+j carried by beat n.
   function automatic int src_k(int n, int nn);
`ifdef MAT_STREAM_TRANSPOSE_EN
      return (n % nn) * nn + n / nn;
`else
      return n;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Directed data set: element k = (k+1+base) + j(k+5+base).
   task automatic set_mat(input int base);
      for (int k = 0; k < 4; k++) begin
         e_re[k] = $realtobits(real'(k + 1 + base));
         e_im[k] = $realtobits(real'(k + 5 + base));
      end
   endtask

   task automatic expect_elem2(input string tag, input int base, input int p);
      int k;
      k = src_k(p, 2);
      chk({tag, "_valid"}, 64'(o2_valid), 64'd1);
      chk({tag, "_re"}, o2_real, $realtobits(real'(k + 1 + base)));
      chk({tag, "_im"}, o2_imag, $realtobits(real'(k + 5 + base)));
      chk({tag, "_row"}, 64'(o2_row), 64'(k / 2));
      chk({tag, "_col"}, 64'(o2_col), 64'(k % 2));
      chk({tag, "_last"}, 64'(o2_last), 64'(p == 3));
      $display("%s beat %0d: re=%h im=%h row=%0d col=%0d last=%0b",
               tag, p, o2_real, o2_imag, o2_row, o2_col, o2_last);
   endtask

   task automatic push_exp(input int w, input int nn);
      beat_t b;
      for (int n = 0; n < nn * nn; n++) begin
         int k;
         k      = src_k(n, nn);
         b.re   = e_re[k];
         b.im   = e_im[k];
         b.row  = k / nn;
         b.col  = k % nn;
         b.last = (n == nn * nn - 1);
         case (w)
            1:       q1.push_back(b);
            2:       q2.push_back(b);
            default: q3.push_back(b);
         endcase
      end
   endtask

   task automatic mon(input int w, input logic v, input logic [63:0] re, input logic [63:0] im,
                      input int row, input int col, input logic last);
      beat_t b;
      int    sz;
      if (!v) return;
      case (w)
         1:       sz = q1.size();
         2:       sz = q2.size();
         default: sz = q3.size();
      endcase
      n_checks++;
      if (sz == 0) begin
         n_errors++;
         $display("FAIL n%0d_unexpected_beat: got re=%h, expected no valid element", w, re);
         return;
      end
      case (w)
         1:       b = q1[0];
         2:       b = q2[0];
         default: b = q3[0];
      endcase
      chk($sformatf("n%0d_re", w), re, b.re);
      chk($sformatf("n%0d_im", w), im, b.im);
      chk($sformatf("n%0d_row", w), 64'(row), 64'(b.row));
      chk($sformatf("n%0d_col", w), 64'(col), 64'(b.col));
      chk($sformatf("n%0d_last", w), 64'(last), 64'(b.last));
      if (out_ready) begin
         $display("N=%0d beat: re=%h im=%h row=%0d col=%0d last=%0b", w, re, im, row, col, last);
         case (w)
            1:       void'(q1.pop_front());
            2:       void'(q2.pop_front());
            default: void'(q3.pop_front());
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b0; done1 = 1'b0; done2 = 1'b0; done3 = 1'b0;
      for (int k = 0; k < 9; k++) begin
         e_re[k] = '0;
         e_im[k] = '0;
      end
      set_mat(0);

      tbl[0]  = mk(1, 1, 0, 0, 0);  tbl[1]  = mk(1, 1, 1, 0, 0);
      tbl[2]  = mk(0, 1, 1, 1, 0);  tbl[3]  = mk(0, 1, 1, 2, 0);
      tbl[4]  = mk(0, 1, 1, 3, 1);  tbl[5]  = mk(0, 1, 0, 0, 0);
      tbl[6]  = mk(1, 0, 0, 0, 0);  tbl[7]  = mk(0, 1, 1, 0, 0);
      tbl[8]  = mk(0, 0, 1, 1, 0);  tbl[9]  = mk(0, 0, 1, 1, 0);
      tbl[10] = mk(0, 1, 1, 1, 0);  tbl[11] = mk(0, 0, 1, 2, 0);
      tbl[12] = mk(0, 0, 1, 2, 0);  tbl[13] = mk(0, 1, 1, 2, 0);
      tbl[14] = mk(0, 0, 1, 3, 1);  tbl[15] = mk(0, 0, 1, 3, 1);
      tbl[16] = mk(0, 1, 1, 3, 1);  tbl[17] = mk(0, 1, 0, 0, 0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(o2_valid), 64'd0);
      chk("rst_last", 64'(o2_last), 64'd0);
      chk("rst_busy", 64'(o2_busy), 64'd0);
      chk("rst_overrun", 64'(o2_ovr), 64'd0);
      chk("rst_re", o2_real, 64'd0);
      chk("rst_im", o2_imag, 64'd0);
      rst = 1'b0;
      step();

      // Full-throughput and backpressure sequences, table driven
      for (int r = 0; r < 18; r++) begin
         done2     = tbl[r].done;
         out_ready = tbl[r].ready;
         chk($sformatf("tbl%0d_valid", r), 64'(o2_valid), 64'(tbl[r].v));
         chk($sformatf("tbl%0d_busy", r), 64'(o2_busy), 64'(tbl[r].v));
         chk($sformatf("tbl%0d_last", r), 64'(o2_last), 64'(tbl[r].last));
         if (tbl[r].v) begin
            int k;
            k = src_k(tbl[r].p, 2);
            chk($sformatf("tbl%0d_re", r), o2_real, $realtobits(real'(k + 1)));
            chk($sformatf("tbl%0d_im", r), o2_imag, $realtobits(real'(k + 5)));
            chk($sformatf("tbl%0d_row", r), 64'(o2_row), 64'(k / 2));
            chk($sformatf("tbl%0d_col", r), 64'(o2_col), 64'(k % 2));
         end
         $display("tbl row %0d: ready=%0b valid=%0b re=%h im=%h row=%0d col=%0d last=%0b",
                  r, out_ready, o2_valid, o2_real, o2_imag, o2_row, o2_col, o2_last);
         step();
      end
      done2 = 1'b0;

      // Reset mid-stream after two beats
      done2 = 1'b1; out_ready = 1'b1;
      step();
      done2 = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(o2_valid), 64'd0);
      chk("midrst_last", 64'(o2_last), 64'd0);
      chk("midrst_busy", 64'(o2_busy), 64'd0);
      chk("midrst_re", o2_real, 64'd0);
      chk("midrst_im", o2_imag, 64'd0);
      chk("midrst_row", 64'(o2_row), 64'd0);
      chk("midrst_col", 64'(o2_col), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("postrst%0d_valid", c), 64'(o2_valid), 64'd0);
      end

      // Back-to-back matrices: a rise on the last beat chains the next matrix without a gap
      set_mat(0);
      done2 = 1'b1; out_ready = 1'b1;
      step();
      for (int b = 0; b < 8; b++) begin
         expect_elem2((b < 4) ? "b2bA" : "b2bB", (b < 4) ? 0 : 10, b % 4);
         chk($sformatf("b2b%0d_overrun", b), 64'(o2_ovr), 64'd0);
         if (b == 3) begin
            set_mat(10);
            done2 = 1'b1;
         end else begin
            done2 = 1'b0;
         end
         step();
      end
      chk("b2b_end_valid", 64'(o2_valid), 64'd0);

      // Overrun: a second rise mid-stream is dropped and the sticky flag is set
      set_mat(0);
      done2 = 1'b1;
      step();
      for (int p = 0; p < 4; p++) begin
         expect_elem2("ovr", 0, p);
         chk($sformatf("ovr%0d_flag", p), 64'(o2_ovr), 64'(p >= 2));
         if (p == 1) begin
            set_mat(10);
            done2 = 1'b1;
         end else begin
            done2 = 1'b0;
         end
         step();
      end
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("ovr_hold%0d_valid", c), 64'(o2_valid), 64'd0);
         chk($sformatf("ovr_hold%0d_flag", c), 64'(o2_ovr), 64'd1);
         step();
      end

      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("ovr_clear", 64'(o2_ovr), 64'd0);
      step();

      // Random doubles on N=1, 2, 3 with random ready
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 9; k++) begin
            e_re[k] = {$urandom, $urandom};
            e_im[k] = {$urandom, $urandom};
         end
         push_exp(1, 1);
         push_exp(2, 2);
         push_exp(3, 3);
         done1 = 1'b1; done2 = 1'b1; done3 = 1'b1;
         step();
         done1 = 1'b0; done2 = 1'b0; done3 = 1'b0;
         for (int c = 0; c < 300; c++) begin
            if (q1.size() == 0 && q2.size() == 0 && q3.size() == 0) break;
            out_ready = ($urandom_range(0, 3) != 0);
            mon(1, o1_valid, o1_real, o1_imag, int'(o1_row), int'(o1_col), o1_last);
            mon(2, o2_valid, o2_real, o2_imag, int'(o2_row), int'(o2_col), o2_last);
            mon(3, o3_valid, o3_real, o3_imag, int'(o3_row), int'(o3_col), o3_last);
            step();
         end
         chk($sformatf("rnd%0d_n1_drained", it), 64'(q1.size()), 64'd0);
         chk($sformatf("rnd%0d_n2_drained", it), 64'(q2.size()), 64'd0);
         chk($sformatf("rnd%0d_n3_drained", it), 64'(q3.size()), 64'd0);
         chk($sformatf("rnd%0d_n1_idle", it), 64'(o1_valid), 64'd0);
         chk($sformatf("rnd%0d_n2_idle", it), 64'(o2_valid), 64'd0);
         chk($sformatf("rnd%0d_n3_idle", it), 64'(o3_valid), 64'd0);
         chk($sformatf("rnd%0d_n3_overrun", it), 64'(o3_ovr), 64'd0);
         q1.delete(); q2.delete(); q3.delete();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
